// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam int P_CPU  = 0;
    localparam int P_HOST = 1;

    localparam int MAX_LOCK_DEF = 8;

    function automatic int lock_cnt_w(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

    localparam int LOCK_CNT_W = lock_cnt_w(MAX_LOCK_DEF);

endpackage

// File: rtl/dmem_arb_lock_timer.sv
// dmem_arb_lock_timer: lock hold counter; cleared by load, counts up to MAX_LOCK and
// flags expiry once MAX_LOCK-1 lock cycles have elapsed.
module dmem_arb_lock_timer
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF,
    parameter int CW       = lock_cnt_w(MAX_LOCK)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
    localparam logic [CW-1:0] CNT_EXP = CW'(MAX_LOCK - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? '0 : (inc_i && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = cnt_q >= CNT_EXP;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous data memory between the
// CPU (port 0) and a host loader (port 1), with bounded locking and read-data routing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [1:0]            we,
    input  logic [ADDR_BITS-1:0]  addr0,
    input  logic [ADDR_BITS-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [ADDR_BITS-1:0]  maddr_q;
    logic [DATA_WIDTH-1:0] mwdata_q;
    logic [1:0]            rvalid_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    logic                  in_lock, win, lock_exp;

    dmem_arb_lock_timer #(.MAX_LOCK(MAX_LOCK)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (!in_lock),
        .inc_i     (in_lock),
        .expired_o (lock_exp)
    );

    // A lock pins the winner to the owner; otherwise a tie goes to the port not served last.
    always_comb begin
        in_lock = state_q == LOCK0 || state_q == LOCK1;
        win     = in_lock ? (state_q == LOCK1) : (&req ? ~last_q : req[P_HOST]);
        gnt     = (rst || !req[win]) ? 2'b00 : (win ? 2'b10 : 2'b01);
        last_d  = (|gnt || in_lock) ? win : last_q;
        state_d = in_lock ? state_q : FREE;
        if (in_lock && (!lock[win] || lock_exp))
            state_d = FREE;
        else if (!in_lock && |gnt && lock[win] && MAX_LOCK > 1)
            state_d = win ? LOCK1 : LOCK0;
    end

    always_comb begin
        mem_wen   = |gnt && we[win];
        mem_addr  = |gnt ? (win ? addr1 : addr0) : maddr_q;
        mem_wdata = |gnt ? (win ? wdata1 : wdata0) : mwdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            last_q   <= 1'b1;
            maddr_q  <= '0;
            mwdata_q <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            maddr_q  <= mem_addr;
            mwdata_q <= mem_wdata;
            rvalid_q <= gnt & ~we;
            if (rvalid_q[P_CPU])  rdata0_q <= mem_rdata;
            if (rvalid_q[P_HOST]) rdata1_q <= mem_rdata;
        end
    end

    // Return data passes straight through on the valid cycle and is held afterwards.
    assign rvalid = rvalid_q;
    assign rdata0 = rvalid_q[P_CPU]  ? mem_rdata : rdata0_q;
    assign rdata1 = rvalid_q[P_HOST] ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural 32x8 memory.
module tb_dmem_arbiter;

    localparam int DW = 8;
    localparam int AB = 5;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, lock, we, gnt, rvalid;
    logic [AB-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic          mem_wen;
    logic [DW-1:0] mem [0:31];
    int            tests = 0;
    int            fails = 0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic step(input logic r_rst, input logic [1:0] r, input logic [1:0] l,
                        input logic [1:0] w, input logic [AB-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AB-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        rst = r_rst; req = r; lock = l; we = w;
        addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
        #2;
    endtask

    task automatic idle(input logic r_rst);
        step(r_rst, 2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
    endtask

    task automatic test_reset();
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            tests++;
            if ({gnt, mem_wen, mem_addr, mem_wdata, rvalid, rdata0, rdata1} !==
                {2'b00, 1'b0, 5'd0, 8'h00, 2'b00, 8'h00, 8'h00})
                begin fails++; $display("FAIL reset_idle[%0d]: gnt=%b wen=%b addr=%h wd=%h rv=%b rd0=%h rd1=%h, want all zero",
                                        i, gnt, mem_wen, mem_addr, mem_wdata, rvalid, rdata0, rdata1); end
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 2'b01, 2'b00, 2'b01, 5'd3, 8'hA5, 5'd0, 8'h00);
        tests++;
        if ({gnt, mem_wen, mem_addr, mem_wdata} !== {2'b01, 1'b1, 5'd3, 8'hA5})
            begin fails++; $display("FAIL wr_cmd: gnt=%b wen=%b addr=%h wd=%h, want 01 1 03 a5", gnt, mem_wen, mem_addr, mem_wdata); end
        step(1'b0, 2'b01, 2'b00, 2'b00, 5'd3, 8'h00, 5'd0, 8'h00);
        tests++;
        if ({gnt, mem_wen, mem_addr, rvalid} !== {2'b01, 1'b0, 5'd3, 2'b00})
            begin fails++; $display("FAIL rd_cmd: gnt=%b wen=%b addr=%h rv=%b, want 01 0 03 00", gnt, mem_wen, mem_addr, rvalid); end
        idle(1'b0);
        tests++;
        if ({gnt, mem_wen, mem_addr, mem_wdata, rvalid, rdata0} !== {2'b00, 1'b0, 5'd3, 8'h00, 2'b01, 8'hA5})
            begin fails++; $display("FAIL rd_return: gnt=%b wen=%b addr=%h wd=%h rv=%b rd0=%h, want 00 0 03 00 01 a5",
                                    gnt, mem_wen, mem_addr, mem_wdata, rvalid, rdata0); end
        idle(1'b0);
        tests++;
        if ({rvalid, rdata0} !== {2'b00, 8'hA5})
            begin fails++; $display("FAIL rd_hold: rv=%b rd0=%h, want 00 a5", rvalid, rdata0); end
    endtask

    task automatic test_alternate();
        logic [1:0]    exp_g, exp_rv;
        logic [AB-1:0] exp_a;
        logic [15:0]   exp_rd;
        step(1'b0, 2'b01, 2'b00, 2'b01, 5'd1, 8'h11, 5'd0, 8'h00);
        step(1'b0, 2'b01, 2'b00, 2'b01, 5'd2, 8'h22, 5'd0, 8'h00);
        idle(1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'b11, 2'b00, 2'b00, 5'd1, 8'h00, 5'd2, 8'h00);
            exp_g  = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_a  = (i % 2 == 1) ? 5'd2 : 5'd1;
            exp_rv = (i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b01 : 2'b10;
            exp_rd = (i == 0) ? 16'h0000 : (i == 1) ? 16'h1100 : 16'h1122;
            tests++;
            if ({gnt, mem_addr, rvalid, rdata0, rdata1} !== {exp_g, exp_a, exp_rv, exp_rd})
                begin fails++; $display("FAIL alternate[%0d]: gnt=%b addr=%h rv=%b rd=%h%h, want %b %h %b %h",
                                        i, gnt, mem_addr, rvalid, rdata0, rdata1, exp_g, exp_a, exp_rv, exp_rd); end
        end
        idle(1'b0);
        tests++;
        if ({gnt, rvalid, rdata1} !== {2'b00, 2'b10, 8'h22})
            begin fails++; $display("FAIL alternate_tail: gnt=%b rv=%b rd1=%h, want 00 10 22", gnt, rvalid, rdata1); end
    endtask

    task automatic test_lock_host();
        idle(1'b1);
        step(1'b0, 2'b01, 2'b00, 2'b00, 5'd3, 8'h00, 5'd0, 8'h00);
        step(1'b0, 2'b11, 2'b10, 2'b10, 5'd3, 8'h00, 5'd10, 8'h5A);
        tests++;
        if ({gnt, mem_wen, mem_addr, mem_wdata} !== {2'b10, 1'b1, 5'd10, 8'h5A})
            begin fails++; $display("FAIL lock_c0: gnt=%b wen=%b addr=%h wd=%h, want 10 1 0a 5a", gnt, mem_wen, mem_addr, mem_wdata); end
        step(1'b0, 2'b11, 2'b10, 2'b00, 5'd3, 8'h00, 5'd10, 8'h00);
        tests++;
        if ({gnt, mem_wen, mem_addr} !== {2'b10, 1'b0, 5'd10})
            begin fails++; $display("FAIL lock_c1: gnt=%b wen=%b addr=%h, want 10 0 0a", gnt, mem_wen, mem_addr); end
        step(1'b0, 2'b11, 2'b00, 2'b10, 5'd3, 8'h00, 5'd10, 8'h6B);
        tests++;
        if ({gnt, mem_wen, mem_addr, mem_wdata, rvalid, rdata1} !== {2'b10, 1'b1, 5'd10, 8'h6B, 2'b10, 8'h5A})
            begin fails++; $display("FAIL lock_drop: gnt=%b wen=%b addr=%h wd=%h rv=%b rd1=%h, want 10 1 0a 6b 10 5a",
                                    gnt, mem_wen, mem_addr, mem_wdata, rvalid, rdata1); end
        step(1'b0, 2'b01, 2'b00, 2'b00, 5'd3, 8'h00, 5'd0, 8'h00);
        tests++;
        if ({gnt, mem_addr, rvalid} !== {2'b01, 5'd3, 2'b00})
            begin fails++; $display("FAIL lock_after: gnt=%b addr=%h rv=%b, want 01 03 00", gnt, mem_addr, rvalid); end
        idle(1'b0);
        tests++;
        if ({rvalid, rdata0} !== {2'b01, 8'hA5})
            begin fails++; $display("FAIL lock_after_rd: rv=%b rd0=%h, want 01 a5", rvalid, rdata0); end
    endtask

    task automatic test_forced_release();
        logic [1:0] exp_g;
        idle(1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 2'b11, 2'b01, 2'b00, 5'd5, 8'h00, 5'd6, 8'h00);
            exp_g = (i == 5) ? 2'b10 : 2'b01;
            tests++;
            if (gnt !== exp_g)
                begin fails++; $display("FAIL forced_release[%0d]: gnt=%b, want %b", i, gnt, exp_g); end
        end
    endtask

    task automatic test_reset_mid();
        idle(1'b1);
        step(1'b0, 2'b10, 2'b00, 2'b10, 5'd0, 8'h00, 5'd7, 8'h77);
        tests++;
        if ({gnt, mem_wen, mem_addr, mem_wdata} !== {2'b10, 1'b1, 5'd7, 8'h77})
            begin fails++; $display("FAIL rst_pre_wr: gnt=%b wen=%b addr=%h wd=%h, want 10 1 07 77", gnt, mem_wen, mem_addr, mem_wdata); end
        step(1'b0, 2'b01, 2'b01, 2'b00, 5'd3, 8'h00, 5'd0, 8'h00);
        step(1'b1, 2'b11, 2'b01, 2'b10, 5'd3, 8'h00, 5'd7, 8'hEE);
        tests++;
        if ({gnt, mem_wen} !== {2'b00, 1'b0})
            begin fails++; $display("FAIL rst_cmd: gnt=%b wen=%b, want 00 0", gnt, mem_wen); end
        step(1'b0, 2'b10, 2'b00, 2'b00, 5'd0, 8'h00, 5'd7, 8'h00);
        tests++;
        if ({gnt, rvalid} !== {2'b10, 2'b00})
            begin fails++; $display("FAIL rst_free: gnt=%b rv=%b, want 10 00", gnt, rvalid); end
        idle(1'b0);
        tests++;
        if ({rvalid, rdata1} !== {2'b10, 8'h77})
            begin fails++; $display("FAIL rst_kept: rv=%b rd1=%h, want 10 77", rvalid, rdata1); end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_write_read();
        test_alternate();
        test_lock_host();
        test_forced_release();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single data memory (32 × 8-bit, synchronous write, one-cycle registered read) between the CPU control unit (port 0) and a host/debug loader (port 1). It:
- grants at most one memory transaction per cycle, round-robin;
- supports a bounded lock so one requester can run an atomic read-modify-write sequence;
- routes returned read data back to the requester that issued the read.

It sits between the requesters and the memory and owns the memory's address, data-in and write-enable pins.

## Interface
Parameters:
- DATA_WIDTH, 8, data word width
- ADDR_BITS, 5, memory address width (32 words)
- MAX_LOCK, 8, maximum consecutive cycles a lock may hold the memory (1..255)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req[1:0]  in  2  per-port request; held stable with its command until granted
- lock[1:0]  in  2  per-port lock request, sampled with req
- we[1:0]  in  2  per-port write (1) / read (0)
- addr0, addr1  in  ADDR_BITS  per-port address
- wdata0, wdata1  in  DATA_WIDTH  per-port write data
- gnt[1:0]  out  2  combinational one-hot accept, same cycle as command
- rvalid[1:0]  out  2  read data valid, registered
- rdata0, rdata1  out  DATA_WIDTH  read data, valid when the matching rvalid is high
- mem_addr  out  ADDR_BITS  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wen  out  1  memory write enable
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after the address

## Operation
- FSM states:
  - FREE: normal arbitration.
  - LOCK0 / LOCK1: memory reserved for port 0 / port 1.
- FREE:
  - If only one port requests, that port is granted.
  - If both request, the port not granted most recently (pointer `last`) wins.
  - `last` updates to the granted port on every grant.
  - If the granted port also has lock=1, go to LOCKx and clear lock_cnt to 0.
- LOCKx:
  - Only port x can be granted; the other port's req is ignored and gnt stays 0.
  - lock_cnt increments each cycle and saturates at MAX_LOCK.
  - Return to FREE when port x drops lock, or when lock_cnt reaches MAX_LOCK-1 (forced release).
  - On forced release, `last` is set to x, so the other port wins the next tie.
- Granted command drives the memory combinationally:
  - mem_addr and mem_wdata come from the winner.
  - mem_wen = we of the winner.
  - With no grant: mem_wen = 0, and mem_addr / mem_wdata hold their previous value.
- Read return: when a read is granted in cycle N, rvalid[p] pulses in cycle N+1 and rdata_p = mem_rdata.
  - rdata_p is registered, so it holds until that port's next read return.
- Writes produce no rvalid.
- A port may request again in the cycle its rvalid is high; back-to-back grants are allowed (one per cycle).

## Timing
- Reset values:
  - state FREE, last = 1 (so port 0 wins the first tie), lock_cnt 0.
  - gnt 0, mem_wen 0, mem_addr 0, mem_wdata 0.
  - rvalid 0, rdata0 = rdata1 = 0.
- Arbitration and memory command: zero latency (combinational).
- Read latency: one cycle from gnt to rvalid.
- Reset mid-operation:
  - rst=1 forces gnt=0 and mem_wen=0 in the same cycle, so no write commits.
  - An in-flight rvalid due the next cycle is suppressed.
  - Lock state is discarded.
- Simultaneous events:
  - A lock drop and the other port's req in the same cycle: the FSM is FREE next cycle, and the other port is eligible that cycle.
  - Forced release while port x still requests: port x may win again only if the other port is idle.
- MAX_LOCK=1: a lock never outlasts its own grant cycle (equivalent to no lock).

## Structure
- Package `dmem_arb_pkg`:
  - state enum (FREE, LOCK0, LOCK1).
  - port index constants P_CPU=0, P_HOST=1.
  - lock counter width, derived as clog2(MAX_LOCK+1).
- One sub-module: `dmem_arb_lock_timer` (load / increment / saturate counter with an expiry flag).
- Everything else (pick logic, FSM, return pipeline) stays in `dmem_arbiter`.

## Test plan
- Reset then idle: every output is at its reset value and mem_wen=0 for 5 cycles.
- Port 0 writes 0xA5 at addr 3, then port 0 reads addr 3:
  - gnt[0] in the cycle of each command.
  - rvalid[0] one cycle after the read grant, with rdata0 = 0xA5.
- Both ports read continuously (port 0 at addr 1, port 1 at addr 2, memory preloaded with 0x11 and 0x22): grants alternate 0,1,0,1…, starting with port 0 after reset, and the rdata values match.
- Port 1 locks and issues 3 commands while port 0 requests throughout:
  - port 0 gets no gnt until port 1 drops lock.
  - port 0 is granted the cycle after the drop.
- With MAX_LOCK=4, port 0 holds lock and req forever while port 1 requests: port 1 is granted within 5 cycles of port 0's first lock grant.
- Assert rst in the cycle a port-1 write to addr 7 is granted:
  - mem_wen stays 0 and addr 7 keeps its old value.
  - No rvalid follows, and the FSM returns to FREE.
